// File: rtl/fa_chk_pkg.sv
// fa_chk_pkg: shared types and helpers for the full-adder response checker.
//   state_e     - checker FSM states
//   COV_ALL     - coverage map value once all 8 {a,b,cin} combinations are seen
//   fa_expected - golden 1-bit full adder, returns {cout,sum}
package fa_chk_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2,
      ST_HALT = 2'd3
   } state_e;

   localparam logic [7:0] COV_ALL = 8'hFF;

   function automatic logic [1:0] fa_expected(input logic a, input logic b, input logic cin);
      return {1'b0, a} + {1'b0, b} + {1'b0, cin};
   endfunction

endpackage

// File: rtl/fa_ref_model.sv
// fa_ref_model: combinational golden full adder.
//   a_i, b_i, cin_i - adder inputs
//   exp_o           - expected {cout,sum}
module fa_ref_model
   import fa_chk_pkg::*;
(
   input  logic       a_i,
   input  logic       b_i,
   input  logic       cin_i,
   output logic [1:0] exp_o
);

   assign exp_o = fa_expected(a_i, b_i, cin_i);

endmodule

// File: rtl/fa_response_checker.sv
// fa_response_checker: compares full-adder observations against the golden
// model, tracks input coverage, counts pass/fail and captures the first failure.
//   clk, rst_n          - clock, synchronous active-low reset
//   start               - pulse: clear results and begin a run (ignored in RUN)
//   in_valid/in_ready   - observation handshake; in_ready is high only in RUN
//   in_a/in_b/in_cin    - applied adder inputs
//   in_sum/in_cout      - observed adder outputs
//   busy/done/pass/err  - run status and verdict
//   err_vec/err_got     - first failing {a,b,cin} and its observed {cout,sum}
//   cov_map             - bit {a,b,cin} set once that combination is accepted
//   pass_cnt/fail_cnt   - saturating accepted-observation counts
module fa_response_checker
   import fa_chk_pkg::*;
#(
   parameter int unsigned CNT_W        = 16,
   parameter bit          STOP_ON_FAIL = 1'b0
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_a,
   input  logic             in_b,
   input  logic             in_cin,
   input  logic             in_sum,
   input  logic             in_cout,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic             err,
   output logic [2:0]       err_vec,
   output logic [1:0]       err_got,
   output logic [7:0]       cov_map,
   output logic [CNT_W-1:0] pass_cnt,
   output logic [CNT_W-1:0] fail_cnt
);

   state_e           state_q, state_d;
   logic [7:0]       cov_q, cov_d;
   logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
   logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
   logic             err_q, err_d;
   logic [2:0]       err_vec_q, err_vec_d;
   logic [1:0]       err_got_q, err_got_d;

   logic [1:0] exp_w;
   logic [2:0] vec;
   logic [1:0] got;
   logic       accept;
   logic       mism;
   logic [7:0] cov_set;

   fa_ref_model u_ref (
      .a_i   (in_a),
      .b_i   (in_b),
      .cin_i (in_cin),
      .exp_o (exp_w)
   );

   assign vec     = {in_a, in_b, in_cin};
   assign got     = {in_cout, in_sum};
   assign mism    = (got != exp_w);
   assign accept  = in_valid && (state_q == ST_RUN);
   assign cov_set = cov_q | (8'd1 << vec);

   always_comb begin
      state_d    = state_q;
      cov_d      = cov_q;
      pass_cnt_d = pass_cnt_q;
      fail_cnt_d = fail_cnt_q;
      err_d      = err_q;
      err_vec_d  = err_vec_q;
      err_got_d  = err_got_q;

      if (start && (state_q != ST_RUN)) begin
         state_d    = ST_RUN;
         cov_d      = '0;
         pass_cnt_d = '0;
         fail_cnt_d = '0;
         err_d      = 1'b0;
         err_vec_d  = '0;
         err_got_d  = '0;
      end else if (accept) begin
         cov_d = cov_set;
         if (mism) begin
            if (fail_cnt_q != '1) fail_cnt_d = fail_cnt_q + CNT_W'(1);
            err_d = 1'b1;
            // Only the first failure of a run is captured.
            if (!err_q) begin
               err_vec_d = vec;
               err_got_d = got;
            end
         end else begin
            if (pass_cnt_q != '1) pass_cnt_d = pass_cnt_q + CNT_W'(1);
         end
         // Halting takes priority over completing coverage on the same accept.
         if (mism && STOP_ON_FAIL)  state_d = ST_HALT;
         else if (cov_set == COV_ALL) state_d = ST_DONE;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         cov_q      <= '0;
         pass_cnt_q <= '0;
         fail_cnt_q <= '0;
         err_q      <= 1'b0;
         err_vec_q  <= '0;
         err_got_q  <= '0;
      end else begin
         state_q    <= state_d;
         cov_q      <= cov_d;
         pass_cnt_q <= pass_cnt_d;
         fail_cnt_q <= fail_cnt_d;
         err_q      <= err_d;
         err_vec_q  <= err_vec_d;
         err_got_q  <= err_got_d;
      end
   end

   assign in_ready = (state_q == ST_RUN);
   assign busy     = (state_q == ST_RUN);
   assign done     = (state_q == ST_DONE);
   assign pass     = done && (fail_cnt_q == '0);
   assign err      = err_q;
   assign err_vec  = err_vec_q;
   assign err_got  = err_got_q;
   assign cov_map  = cov_q;
   assign pass_cnt = pass_cnt_q;
   assign fail_cnt = fail_cnt_q;

endmodule

// File: tb/tb_fa_response_checker.sv
// Directed bench: three checkers share one stimulus stream
//   u0 default parameters, u1 STOP_ON_FAIL=1, u2 CNT_W=2.
module tb_fa_response_checker;

   logic clk = 1'b0;
   logic rst_n, start, in_valid, in_a, in_b, in_cin, in_sum, in_cout;

   logic r0, b0, d0, p0, e0;  logic [2:0] ev0; logic [1:0] eg0; logic [7:0] c0; logic [15:0] pc0, fc0;
   logic r1, b1, d1, p1, e1;  logic [2:0] ev1; logic [1:0] eg1; logic [7:0] c1; logic [15:0] pc1, fc1;
   logic r2, b2, d2, p2, e2;  logic [2:0] ev2; logic [1:0] eg2; logic [7:0] c2; logic [1:0]  pc2, fc2;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   fa_response_checker #(.CNT_W(16), .STOP_ON_FAIL(1'b0)) u0 (
      .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(r0),
      .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sum(in_sum), .in_cout(in_cout),
      .busy(b0), .done(d0), .pass(p0), .err(e0), .err_vec(ev0), .err_got(eg0),
      .cov_map(c0), .pass_cnt(pc0), .fail_cnt(fc0));

   fa_response_checker #(.CNT_W(16), .STOP_ON_FAIL(1'b1)) u1 (
      .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(r1),
      .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sum(in_sum), .in_cout(in_cout),
      .busy(b1), .done(d1), .pass(p1), .err(e1), .err_vec(ev1), .err_got(eg1),
      .cov_map(c1), .pass_cnt(pc1), .fail_cnt(fc1));

   fa_response_checker #(.CNT_W(2), .STOP_ON_FAIL(1'b0)) u2 (
      .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(r2),
      .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sum(in_sum), .in_cout(in_cout),
      .busy(b2), .done(d2), .pass(p2), .err(e2), .err_vec(ev2), .err_got(eg2),
      .cov_map(c2), .pass_cnt(pc2), .fail_cnt(fc2));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [1:0] fa_sum(input logic [2:0] v);
      return {1'b0, v[2]} + {1'b0, v[1]} + {1'b0, v[0]};
   endfunction

   // One cycle of stimulus; returns at #1 after the edge that samples it.
   task automatic send(input logic v, input logic [2:0] vec, input logic [1:0] got);
      in_valid = v;
      {in_a, in_b, in_cin} = vec;
      {in_cout, in_sum} = got;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic good(input logic [2:0] vec);
      send(1'b1, vec, fa_sum(vec));
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic chk_reset0(input string tag);
      chk({tag, ".ready"}, r0, 0);
      chk({tag, ".busy"},  b0, 0);
      chk({tag, ".done"},  d0, 0);
      chk({tag, ".pass"},  p0, 0);
      chk({tag, ".err"},   e0, 0);
      chk({tag, ".evec"},  ev0, 0);
      chk({tag, ".egot"},  eg0, 0);
      chk({tag, ".cov"},   c0, 0);
      chk({tag, ".pcnt"},  pc0, 0);
      chk({tag, ".fcnt"},  fc0, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; start = 1'b0; in_valid = 1'b0;
      in_a = 1'b0; in_b = 1'b0; in_cin = 1'b0; in_sum = 1'b0; in_cout = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk_reset0("rst");
      rst_n = 1'b1;

      // Clean run, 000..111 back-to-back.
      pulse_start();
      chk("clean.busy", b0, 1);
      chk("clean.ready", r0, 1);
      for (int i = 0; i < 7; i++) good(3'(i));
      chk("clean.done7", d0, 0);
      chk("clean.cov7", c0, 8'h7F);
      good(3'b111);
      chk("clean.done", d0, 1);
      chk("clean.pass", p0, 1);
      chk("clean.pcnt", pc0, 8);
      chk("clean.fcnt", fc0, 0);
      chk("clean.cov", c0, 8'hFF);
      chk("clean.ready_off", r0, 0);
      chk("clean.busy_off", b0, 0);

      // 011 observed as 00, continue to completion.
      pulse_start();
      chk("rerun.cov_clr", c0, 0);
      chk("rerun.pcnt_clr", pc0, 0);
      for (int i = 0; i < 8; i++) begin
         if (i == 3) send(1'b1, 3'b011, 2'b00);
         else        good(3'(i));
      end
      chk("m011.fcnt", fc0, 1);
      chk("m011.pcnt", pc0, 7);
      chk("m011.err", e0, 1);
      chk("m011.evec", ev0, 3'b011);
      chk("m011.egot", eg0, 2'b00);
      chk("m011.done", d0, 1);
      chk("m011.pass", p0, 0);

      // STOP_ON_FAIL: mismatch on the 3rd accept.
      pulse_start();
      good(3'b000);
      good(3'b001);
      send(1'b1, 3'b010, 2'b00);
      chk("halt.busy", b1, 0);
      chk("halt.ready", r1, 0);
      chk("halt.done", d1, 0);
      chk("halt.pcnt", pc1, 2);
      chk("halt.fcnt", fc1, 1);
      chk("halt.cov", c1, 8'h07);
      chk("halt.evec", ev1, 3'b010);
      chk("nohalt.busy", b0, 1);
      good(3'b011);
      chk("halt.hold_pcnt", pc1, 2);
      chk("halt.hold_cov", c1, 8'h07);
      chk("nohalt.pcnt", pc0, 3);

      // start while RUN is ignored; from HALT it restarts.
      pulse_start();
      chk("runstart.pcnt", pc0, 3);
      chk("runstart.cov", c0, 8'h0F);
      chk("runstart.fcnt", fc0, 1);
      chk("haltstart.busy", b1, 1);
      chk("haltstart.cov", c1, 0);
      chk("haltstart.fcnt", fc1, 0);
      chk("haltstart.err", e1, 0);

      // Completing coverage on a failing accept: HALT wins.
      for (int i = 0; i < 7; i++) good(3'(i));
      send(1'b1, 3'b111, 2'b00);
      chk("halt_win.done", d1, 0);
      chk("halt_win.busy", b1, 0);
      chk("halt_win.cov", c1, 8'hFF);
      chk("halt_win.pcnt", pc1, 7);
      chk("halt_win.egot", eg1, 2'b00);
      chk("halt_win.evec", ev1, 3'b111);
      chk("halt_win.u0_done", d0, 1);

      // Repeats and in_valid gaps.
      pulse_start();
      repeat (5) good(3'b101);
      chk("rep.pcnt5", pc0, 5);
      chk("rep.cov5", c0, 8'h20);
      send(1'b0, 3'b111, 2'b00);
      chk("gap.pcnt", pc0, 5);
      chk("gap.fcnt", fc0, 0);
      chk("gap.cov", c0, 8'h20);
      chk("gap.err", e0, 0);
      for (int i = 0; i < 8; i++) begin
         if (i != 5) begin
            good(3'(i));
            if (i == 6) chk("rep.done_pre", d0, 0);
            send(1'b0, 3'(i), ~fa_sum(3'(i)));
         end
      end
      chk("rep.pcnt", pc0, 12);
      chk("rep.fcnt", fc0, 0);
      chk("rep.done", d0, 1);
      chk("rep.pass", p0, 1);

      // Reset mid-run overrides start and an accept on the same edge.
      pulse_start();
      for (int i = 0; i < 4; i++) good(3'(i));
      chk("mid.pcnt", pc0, 4);
      rst_n = 1'b0;
      start = 1'b1;
      send(1'b1, 3'b100, 2'b11);
      start = 1'b0;
      chk_reset0("midrst");
      rst_n = 1'b1;
      pulse_start();
      for (int i = 7; i >= 0; i--) good(3'(i));
      chk("postrst.pass", p0, 1);
      chk("postrst.pcnt", pc0, 8);

      // Saturation with CNT_W=2; first failure is held.
      pulse_start();
      send(1'b1, 3'b110, 2'b11);
      for (int i = 0; i < 3; i++) send(1'b1, 3'b110, 2'b00);
      chk("sat.fcnt4", fc2, 3);
      send(1'b1, 3'b110, 2'b00);
      chk("sat.fcnt5", fc2, 3);
      chk("sat.evec", ev2, 3'b110);
      chk("sat.egot", eg2, 2'b11);
      chk("sat.pcnt", pc2, 0);
      chk("sat.u0_fcnt", fc0, 5);
      chk("sat.cov", c2, 8'h40);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/fa_response_checker.md
# fa_response_checker

Hardware response checker for the 1-bit full adder: the receiving end of the exhaustive A/B/CIN stimulus stream. It accepts one {A, B, CIN, SUM, COUT} observation per handshake and compares SUM/COUT against a golden model. It tracks which of the 8 input combinations have been seen, counts passes and failures, and captures the first failing vector. It sits beside the full adder in self-test builds and replaces printed truth-table inspection with a registered pass/fail verdict.

## Interface
- CNT_W, 16: width of pass/fail counters.
- STOP_ON_FAIL, 0: 1 = halt acceptance after the first mismatch.

- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse; clears results and begins a run.
- in_valid  in  1  observation present.
- in_ready  out  1  checker accepts observation this cycle.
- in_a, in_b, in_cin  in  1 each  applied adder inputs.
- in_sum, in_cout  in  1 each  observed adder outputs.
- busy  out  1  state is RUN.
- done  out  1  all 8 combinations covered.
- pass  out  1  done and zero failures.
- err  out  1  sticky; at least one mismatch this run.
- err_vec  out  3  first failing {a,b,cin}.
- err_got  out  2  first failing observed {cout,sum}.
- cov_map  out  8  bit {a,b,cin} set once that combination is accepted.
- pass_cnt, fail_cnt  out  CNT_W each  accepted-observation counts.

## Operation
- States: IDLE, RUN, DONE, HALT. Reset enters IDLE.
- IDLE/DONE/HALT + start: clear cov_map, counters, err, err_vec, err_got; next state RUN.
- start in RUN is ignored.
- in_ready = (state == RUN), decoded from state only; never depends on in_valid.
- Accept = in_valid & in_ready. Observations with in_valid low change nothing.
- Expected {cout,sum} = in_a + in_b + in_cin (2-bit sum).
- Match: pass_cnt += 1. Mismatch: fail_cnt += 1 and err <= 1.
- On the first mismatch only (err was 0), load err_vec and err_got.
- Counters saturate at all-ones; they never wrap.
- Every accept sets cov_map[{a,b,cin}]. Repeated vectors re-count but do not change coverage.
- RUN -> DONE on the accept that makes cov_map == 8'hFF.
- RUN -> HALT on a mismatch accept when STOP_ON_FAIL = 1.
  - If both apply on the same accept, HALT wins; done stays 0.
- pass = done & (fail_cnt == 0). In DONE, pass equals ~err.
- DONE and HALT hold all results until start or reset.

## Timing
- Reset values: in_ready 0, busy 0, done 0, pass 0, err 0, err_vec 0, err_got 0, cov_map 0, counters 0.
- Every output except in_ready is registered and reflects an accept on the next rising edge (1-cycle latency).
- The 8th distinct accept at edge N: done and pass are visible after edge N, and in_ready is low from that cycle.
- start at edge N: results are cleared and busy = 1 after edge N. The first accept is possible in cycle N+1.
- Back-to-back accepts at one per cycle are supported with no bubbles.
- rst_n low mid-run: all state returns to reset values at that edge, overriding start and accept.

## Structure
- Package fa_chk_pkg:
  - state enum (IDLE, RUN, DONE, HALT);
  - COV_ALL = 8'hFF;
  - function fa_expected(a, b, cin) returning {cout,sum}.
- Sub-module fa_ref_model: purely combinational golden model wrapping fa_expected. It is reused later by serial-adder checkers.
- Top level holds the FSM, coverage register, counters and first-fail capture.

## Test plan
- Reset, start, then 8 correct vectors 000..111 back-to-back:
  - pass_cnt = 8, fail_cnt = 0, cov_map = FF;
  - done = pass = 1 one cycle after the 8th accept;
  - in_ready = 0 afterwards.
- Vector 011 observed as {cout,sum} = 00, others correct, STOP_ON_FAIL = 0:
  - fail_cnt = 1, err = 1, err_vec = 011, err_got = 00;
  - done = 1, pass = 0.
- STOP_ON_FAIL = 1, mismatch on the 3rd accept:
  - state HALT, in_ready = 0, pass_cnt = 2, fail_cnt = 1;
  - cov_map has 3 bits set; done = 0.
- Vector 101 sent 5 times, then the other 7 interleaved with in_valid gaps:
  - pass_cnt = 12;
  - done asserts only after 110/111 etc. complete coverage;
  - cycles with in_valid low change nothing.
- rst_n low after 4 accepts: all outputs return to reset values. start afterwards runs cleanly to pass = 1.
- CNT_W = 2, 5 mismatching accepts of the same vector: fail_cnt saturates at 3, err_vec holds the first failure.
